// File: rtl/uart_tx_arbiter_if.sv
// Bundle for the shared UART TX arbiter: requester side and UART side.
// slave  : used by the arbiter itself (answers requests, drives the UART).
// master : used by whatever drives requests and models the UART.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_par_en;
    logic [NUM_REQ-1:0]            req_par_typ;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            tx_done;
    logic [ID_W-1:0]               grant_id;
    logic                          timeout_err;
    logic [DATA_WIDTH-1:0]         p_data;
    logic                          data_valid;
    logic                          par_en;
    logic                          par_typ;
    logic                          busy;

    modport slave (
        input  req_valid, req_data, req_par_en, req_par_typ, busy,
        output req_ready, tx_done, grant_id, timeout_err,
               p_data, data_valid, par_en, par_typ
    );

    modport master (
        output req_valid, req_data, req_par_en, req_par_typ, busy,
        input  req_ready, tx_done, grant_id, timeout_err,
               p_data, data_valid, par_en, par_typ
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// The winner's byte and parity settings are latched and held for the whole
// frame, since the UART computes parity combinationally from P_DATA.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         rr_q, rr_d;
    logic [ID_W-1:0]         gid_q, gid_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   pdata_q, pdata_d;
    logic                    pen_q, pen_d;
    logic                    ptyp_q, ptyp_d;
    logic [NUM_REQ-1:0]      ready_q, ready_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic                    dv_q, dv_d;

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_data;
    logic                    found;
    logic [ID_W-1:0]         win;
    logic [ID_W-1:0]         idx;

    assign lane_data = bus.req_data;

    // Round-robin search: first valid requester after the last one served.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_q) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gid_d   = gid_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        pdata_d = pdata_q;
        pen_d   = pen_q;
        ptyp_d  = ptyp_q;
        ready_d = '0;
        done_d  = '0;
        dv_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // BUSY high here means the UART is in use elsewhere: hold off.
                if (found && !bus.busy) begin
                    pdata_d      = lane_data[win];
                    pen_d        = bus.req_par_en[win];
                    ptyp_d       = bus.req_par_typ[win];
                    ready_d[win] = 1'b1;
                    gid_d        = win;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                dv_d    = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A low BUSY here only means the frame has not started yet.
                if (bus.busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    rr_d    = gid_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.busy) begin
                    done_d[gid_q] = 1'b1;
                    rr_d          = gid_q;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; rr starts at the top index so req0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= ID_W'(NUM_REQ - 1);
            gid_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            pdata_q <= '0;
            pen_q   <= 1'b0;
            ptyp_q  <= 1'b0;
            ready_q <= '0;
            done_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pdata_q <= pdata_d;
            pen_q   <= pen_d;
            ptyp_q  <= ptyp_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            dv_q    <= dv_d;
        end
    end

    assign bus.req_ready   = ready_q;
    assign bus.tx_done     = done_q;
    assign bus.grant_id    = gid_q;
    assign bus.timeout_err = err_q;
    assign bus.p_data      = pdata_q;
    assign bus.data_valid  = dv_q;
    assign bus.par_en      = pen_q;
    assign bus.par_typ     = ptyp_q;
endmodule
